// File: rtl/ysyx_22051468_branch_ctrl_if.sv
// Request, redirect, response and statistics signals of the branch unit.
// The master side issues branches and the slave side resolves them.
interface ysyx_22051468_branch_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] op_1;
  logic [WIDTH-1:0] op_2;
  logic [WIDTH-1:0] imm;
  logic [2:0]       br_type;
  logic             pred_taken;
  logic [WIDTH-1:0] pred_target;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [WIDTH-1:0] redirect_pc;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_taken;
  logic [WIDTH-1:0] resp_link;
  logic             resp_mispred;
  logic             kill;
  logic             clr_cnt;
  logic [31:0]      br_cnt;
  logic [31:0]      mis_cnt;

  modport master (
    output in_valid, pc, op_1, op_2, imm, br_type, pred_taken, pred_target,
    output redirect_ready, resp_ready, kill, clr_cnt,
    input  in_ready, redirect_valid, redirect_pc,
    input  resp_valid, resp_taken, resp_link, resp_mispred, br_cnt, mis_cnt
  );

  modport slave (
    input  in_valid, pc, op_1, op_2, imm, br_type, pred_taken, pred_target,
    input  redirect_ready, resp_ready, kill, clr_cnt,
    output in_ready, redirect_valid, redirect_pc,
    output resp_valid, resp_taken, resp_link, resp_mispred, br_cnt, mis_cnt
  );
endinterface

// File: rtl/ysyx_22051468_branch_ctrl.sv
// Branch resolution unit: accepts one branch, evaluates it in a single cycle,
// optionally redirects fetch on a mispredict, then reports the result to writeback.
module ysyx_22051468_branch_ctrl #(
  parameter int WIDTH = 64
) (
  input logic clk,
  input logic rst_n,
  ysyx_22051468_branch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EVAL, REDIR, RESP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, op1_q, op2_q, imm_q, pred_target_q;
  logic [2:0]       type_q;
  logic             pred_taken_q;
  logic             taken_q, mispred_q;
  logic [WIDTH-1:0] link_q, next_pc_q;
  logic [31:0]      br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  logic             accept, redir_hs, resp_hs;
  logic             taken_c, mispred_c;
  logic [WIDTH-1:0] target_c, link_c, next_pc_c;

  always_comb begin
    taken_c = 1'b0;
    case (type_q)
      3'd0:    taken_c = (op1_q == op2_q);
      3'd1:    taken_c = (op1_q != op2_q);
      3'd2:    taken_c = ($signed(op1_q) < $signed(op2_q));
      3'd3:    taken_c = !($signed(op1_q) < $signed(op2_q));
      3'd4:    taken_c = (op1_q < op2_q);
      3'd5:    taken_c = !(op1_q < op2_q);
      default: taken_c = 1'b1;
    endcase
    target_c = pc_q + imm_q;
    if (type_q == 3'd7) begin
      target_c    = op1_q + imm_q;
      target_c[0] = 1'b0;
    end
    link_c    = pc_q + WIDTH'(4);
    next_pc_c = taken_c ? target_c : link_c;
    mispred_c = (taken_c != pred_taken_q) |
                (taken_c & pred_taken_q & (target_c != pred_target_q));
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    redir_hs = 1'b0;
    resp_hs  = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = EVAL;
      end
      EVAL: state_d = mispred_c ? REDIR : RESP;
      REDIR: if (bus.redirect_ready) begin
        redir_hs = 1'b1;
        state_d  = RESP;
      end
      RESP: if (bus.resp_ready) begin
        resp_hs = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flush from an older instruction cancels whatever would complete this cycle.
    if (bus.kill) begin
      state_d  = IDLE;
      accept   = 1'b0;
      redir_hs = 1'b0;
      resp_hs  = 1'b0;
    end
  end

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (bus.clr_cnt) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else begin
      if (resp_hs && br_cnt_q != 32'hFFFF_FFFF)   br_cnt_d  = br_cnt_q + 32'd1;
      if (redir_hs && mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      imm_q         <= '0;
      type_q        <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      taken_q       <= 1'b0;
      mispred_q     <= 1'b0;
      link_q        <= '0;
      next_pc_q     <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      if (accept) begin
        pc_q          <= bus.pc;
        op1_q         <= bus.op_1;
        op2_q         <= bus.op_2;
        imm_q         <= bus.imm;
        type_q        <= bus.br_type;
        pred_taken_q  <= bus.pred_taken;
        pred_target_q <= bus.pred_target;
      end
      if (state_q == EVAL && !bus.kill) begin
        taken_q   <= taken_c;
        mispred_q <= mispred_c;
        link_q    <= link_c;
        next_pc_q <= next_pc_c;
      end
    end
  end

  // Outputs are forced quiet while reset is held, even though the FSM already sits in IDLE.
  assign bus.in_ready       = rst_n & (state_q == IDLE);
  assign bus.redirect_valid = rst_n & (state_q == REDIR);
  assign bus.redirect_pc    = rst_n ? next_pc_q : '0;
  assign bus.resp_valid     = rst_n & (state_q == RESP);
  assign bus.resp_taken     = rst_n & taken_q;
  assign bus.resp_link      = rst_n ? link_q : '0;
  assign bus.resp_mispred   = rst_n & mispred_q;
  assign bus.br_cnt         = rst_n ? br_cnt_q : '0;
  assign bus.mis_cnt        = rst_n ? mis_cnt_q : '0;
endmodule

// File: tb/tb_ysyx_22051468_branch_ctrl.sv
// Directed bench for the branch unit: a vector table of branches plus
// hand-written kill, saturation, clear and mid-operation reset sequences.
module tb_ysyx_22051468_branch_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_22051468_branch_ctrl_if #(.WIDTH(64)) bus ();

  ysyx_22051468_branch_ctrl #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [2:0]  br_type;
    logic [63:0] pc;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] imm;
    logic        pt;
    logic [63:0] ptg;
    logic        exp_redir;
    logic [63:0] exp_rpc;
    logic        exp_taken;
    logic [63:0] exp_link;
    logic [3:0]  hold;
  } vec_t;

  vec_t        vecs [9];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] exp_br  = 32'd0;
  logic [31:0] exp_mis = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.pc          = v.pc;
    bus.op_1        = v.op1;
    bus.op_2        = v.op2;
    bus.imm         = v.imm;
    bus.br_type     = v.br_type;
    bus.pred_taken  = v.pt;
    bus.pred_target = v.ptg;
  endtask

  // Present the request, let it be accepted, and stop at the T+2 negedge.
  task automatic send(input vec_t v);
    @(negedge clk);
    drive(v);
    bus.in_valid = 1'b1;
    chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("eval_no_redirect", {63'd0, bus.redirect_valid}, 64'd0);
    chk("eval_no_resp", {63'd0, bus.resp_valid}, 64'd0);
    @(negedge clk);
  endtask

  task automatic finish_redir(input vec_t v);
    for (int h = 0; h < int'(v.hold); h++) begin
      chk("redirect_hold_valid", {63'd0, bus.redirect_valid}, 64'd1);
      chk("redirect_hold_pc", bus.redirect_pc, v.exp_rpc);
      @(negedge clk);
    end
    chk("redirect_valid", {63'd0, bus.redirect_valid}, 64'd1);
    chk("redirect_pc", bus.redirect_pc, v.exp_rpc);
    chk("redirect_no_resp", {63'd0, bus.resp_valid}, 64'd0);
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    bus.redirect_ready = 1'b0;
    if (exp_mis != 32'hFFFF_FFFF) exp_mis++;
  endtask

  task automatic finish_resp(input vec_t v);
    for (int h = 0; h < int'(v.hold); h++) begin
      chk("resp_hold_valid", {63'd0, bus.resp_valid}, 64'd1);
      chk("resp_hold_link", bus.resp_link, v.exp_link);
      @(negedge clk);
    end
    chk("resp_valid", {63'd0, bus.resp_valid}, 64'd1);
    chk("resp_no_redirect", {63'd0, bus.redirect_valid}, 64'd0);
    chk("resp_taken", {63'd0, bus.resp_taken}, {63'd0, v.exp_taken});
    chk("resp_link", bus.resp_link, v.exp_link);
    chk("resp_mispred", {63'd0, bus.resp_mispred}, {63'd0, v.exp_redir});
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    if (exp_br != 32'hFFFF_FFFF) exp_br++;
    chk("br_cnt", {32'd0, bus.br_cnt}, {32'd0, exp_br});
    chk("mis_cnt", {32'd0, bus.mis_cnt}, {32'd0, exp_mis});
    chk("in_ready_after", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    send(v);
    chk("t2_redirect", {63'd0, bus.redirect_valid}, {63'd0, v.exp_redir});
    chk("t2_resp", {63'd0, bus.resp_valid}, {63'd0, ~v.exp_redir});
    if (v.exp_redir) finish_redir(v);
    finish_resp(v);
    $display("vec %0d type=%0d pc=%h redirect=%0d link=%h br_cnt=%0d mis_cnt=%0d",
             idx, v.br_type, v.pc, v.exp_redir, v.exp_link, bus.br_cnt, bus.mis_cnt);
  endtask

  initial begin
    //          type  pc                      op1                     op2                     imm                     pt    ptg       redir rpc       taken link      hold
    vecs[0] = '{3'd0, 64'h1000,               64'd5,                  64'd5,                  64'h20,                 1'b1, 64'h1020, 1'b0, 64'h0,    1'b1, 64'h1004, 4'd1};
    vecs[1] = '{3'd2, 64'h2000,               64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0,    1'b1, 64'h1FF8, 1'b1, 64'h2004, 4'd3};
    vecs[2] = '{3'd4, 64'h4000,               64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 64'h40,                 1'b1, 64'h4040, 1'b1, 64'h4004, 1'b0, 64'h4004, 4'd0};
    vecs[3] = '{3'd7, 64'hFFFF_FFFF_FFFF_FFFC, 64'h3001,              64'd0,                  64'h10,                 1'b1, 64'h3010, 1'b0, 64'h0,    1'b1, 64'h0,    4'd0};
    vecs[4] = '{3'd1, 64'h500,                64'd7,                  64'd7,                  64'h100,                1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h504,  4'd2};
    vecs[5] = '{3'd3, 64'h600,                64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 64'h10,               1'b0, 64'h0,    1'b1, 64'h610,  1'b1, 64'h604,  4'd0};
    vecs[6] = '{3'd5, 64'h700,                64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 64'h20,                1'b0, 64'h0,    1'b0, 64'h0,    1'b0, 64'h704,  4'd0};
    vecs[7] = '{3'd6, 64'h800,                64'd0,                  64'd0,                  64'h80,                 1'b1, 64'h900,  1'b1, 64'h880,  1'b1, 64'h804,  4'd1};
    vecs[8] = '{3'd0, 64'h900,                64'd1,                  64'd2,                  64'h10,                 1'b1, 64'h910,  1'b1, 64'h904,  1'b0, 64'h904,  4'd0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.redirect_ready = 1'b0; bus.resp_ready = 1'b0;
    bus.kill = 1'b0; bus.clr_cnt = 1'b0;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 64'd0);
    chk("rst_resp_link", bus.resp_link, 64'd0);
    chk("rst_br_cnt", {32'd0, bus.br_cnt}, 64'd0);
    chk("rst_mis_cnt", {32'd0, bus.mis_cnt}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Kill while a request is offered in IDLE: nothing is accepted.
    @(negedge clk);
    drive(vecs[0]);
    bus.in_valid = 1'b1; bus.kill = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.kill = 1'b0;
    chk("kill_idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    chk("kill_idle_no_resp", {63'd0, bus.resp_valid}, 64'd0);
    $display("seq kill_idle in_ready=%0d", bus.in_ready);

    // Kill in REDIR together with redirect_ready: back to IDLE, not counted.
    send(vecs[1]);
    chk("kill_redir_pre", {63'd0, bus.redirect_valid}, 64'd1);
    bus.kill = 1'b1; bus.redirect_ready = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0; bus.redirect_ready = 1'b0;
    chk("kill_redir_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("kill_redir_mis_cnt", {32'd0, bus.mis_cnt}, {32'd0, exp_mis});
    chk("kill_redir_no_resp", {63'd0, bus.resp_valid}, 64'd0);
    $display("seq kill_redir mis_cnt=%0d", bus.mis_cnt);

    // Kill in RESP together with resp_ready: not counted.
    send(vecs[0]);
    bus.kill = 1'b1; bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0; bus.resp_ready = 1'b0;
    chk("kill_resp_br_cnt", {32'd0, bus.br_cnt}, {32'd0, exp_br});
    chk("kill_resp_in_ready", {63'd0, bus.in_ready}, 64'd1);
    $display("seq kill_resp br_cnt=%0d", bus.br_cnt);

    // Saturation of the mispredict counter from a preloaded maximum.
    @(negedge clk);
    dut.mis_cnt_q = 32'hFFFF_FFFF;
    exp_mis = 32'hFFFF_FFFF;
    run_vec(7);
    chk("sat_mis_cnt", {32'd0, bus.mis_cnt}, 64'hFFFF_FFFF);

    // Clear in the same cycle as a redirect handshake wins.
    send(vecs[8]);
    bus.clr_cnt = 1'b1; bus.redirect_ready = 1'b1;
    @(negedge clk);
    bus.clr_cnt = 1'b0; bus.redirect_ready = 1'b0;
    exp_mis = 32'd0; exp_br = 32'd0;
    chk("clr_mis_cnt", {32'd0, bus.mis_cnt}, 64'd0);
    chk("clr_br_cnt", {32'd0, bus.br_cnt}, 64'd0);
    finish_resp(vecs[8]);
    $display("seq clr br_cnt=%0d mis_cnt=%0d", bus.br_cnt, bus.mis_cnt);

    // Reset during EVAL discards the branch and clears the counters.
    @(negedge clk);
    drive(vecs[1]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_br = 32'd0; exp_mis = 32'd0;
    chk("midrst_idle", {63'd0, bus.in_ready}, 64'd1);
    chk("midrst_no_redirect", {63'd0, bus.redirect_valid}, 64'd0);
    chk("midrst_no_resp", {63'd0, bus.resp_valid}, 64'd0);
    chk("midrst_br_cnt", {32'd0, bus.br_cnt}, 64'd0);
    chk("midrst_mis_cnt", {32'd0, bus.mis_cnt}, 64'd0);
    $display("seq midrst in_ready=%0d", bus.in_ready);
    run_vec(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ysyx_22051468_branch_ctrl.md
YSYX_22051468_BRANCH_CTRL -- requirements
Module: ysyx_22051468_branch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  branch request valid.
REQ-005 SHALL have port in_ready  out  1  request accepted when in_valid & in_ready.
REQ-006 SHALL have port pc  in  WIDTH  PC of branch instruction.
REQ-007 SHALL have ports op_1, op_2  in  WIDTH  rs1/rs2 operand values.
REQ-008 SHALL have port imm  in  WIDTH  sign-extended immediate.
REQ-009 SHALL have port br_type  in  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL, 7 JALR.
REQ-010 SHALL have ports pred_taken  in  1 and pred_target  in  WIDTH  front-end prediction.
REQ-011 SHALL have ports redirect_valid  out  1, redirect_ready  in  1, redirect_pc  out  WIDTH  fetch redirect handshake.
REQ-012 SHALL have ports resp_valid  out  1, resp_ready  in  1, resp_taken  out  1, resp_link  out  WIDTH, resp_mispred  out  1  result to writeback.
REQ-013 SHALL have port kill  in  1  pipeline flush from older instruction.
REQ-014 SHALL have ports clr_cnt  in  1, br_cnt  out  32, mis_cnt  out  32  statistics.

Function
REQ-015 SHALL implement FSM states IDLE, EVAL, REDIR, RESP.
REQ-016 SHALL drive in_ready=1 only in IDLE; no other state accepts requests.
REQ-017 SHALL on accept in IDLE register pc, op_1, op_2, imm, br_type, pred_taken, pred_target and go to EVAL.
REQ-018 SHALL in EVAL compute taken: BEQ op_1==op_2; BNE !=; BLT/BGE signed op_1<op_2 / !<; BLTU/BGEU unsigned; JAL, JALR always 1.
REQ-019 SHALL compute target = pc+imm for types 0-6, (op_1+imm) with bit0 cleared for JALR; all sums modulo 2^WIDTH (wrap, no carry out).
REQ-020 SHALL compute link = pc+4 (modulo 2^WIDTH) and next_pc = taken ? target : link.
REQ-021 SHALL set mispred = (taken != pred_taken) | (taken & pred_taken & target != pred_target).
REQ-022 SHALL register taken, link, next_pc, mispred at end of EVAL; EVAL lasts exactly 1 cycle.
REQ-023 SHALL transition EVAL->REDIR if mispred, else EVAL->RESP.
REQ-024 SHALL in REDIR hold redirect_valid=1 and redirect_pc=next_pc stable until redirect_ready; on handshake go to RESP.
REQ-025 SHALL in RESP hold resp_valid=1 with resp_taken, resp_link, resp_mispred stable until resp_ready; on handshake go to IDLE.
REQ-026 SHALL give latency: accept at cycle T -> redirect_valid or resp_valid first high at T+2.
REQ-027 SHALL deassert redirect_valid outside REDIR and resp_valid outside RESP.
REQ-028 SHALL on kill=1 in any state go to IDLE next cycle; kill has priority over accept, redirect and resp handshakes in the same cycle (none counted as completed, no counter update).
REQ-029 SHALL increment br_cnt on each resp handshake and mis_cnt on each redirect handshake; both saturate at 32'hFFFF_FFFF.
REQ-030 SHALL on clr_cnt=1 clear both counters; clr_cnt has priority over a same-cycle increment.
REQ-031 SHALL not accept a new request in the cycle a resp handshake occurs (in_ready low in RESP).

Reset
REQ-032 SHALL on rst_n=0 at a clock edge enter IDLE, clear br_cnt, mis_cnt and all registered result fields to 0.
REQ-033 SHALL while in reset drive in_ready=0, redirect_valid=0, resp_valid=0, redirect_pc=0, resp_*=0.
REQ-034 SHALL on reset mid-operation discard the in-flight branch with no redirect, response or count.

Verification
REQ-035 SHALL verify BEQ op_1=op_2=5, pc=0x1000, imm=0x20, pred_taken=1, pred_target=0x1020 -> no redirect; resp_valid at T+2, resp_taken=1, resp_link=0x1004, resp_mispred=0; br_cnt=1.
REQ-036 SHALL verify BLT op_1=-1, op_2=1, pred_taken=0, pc=0x2000, imm=-8 -> redirect_pc=0x1FF8 at T+2, held 3 cycles with redirect_ready=0, then RESP; mis_cnt=1.
REQ-037 SHALL verify BLTU op_1=0xFFFF_FFFF_FFFF_FFFF, op_2=1 -> taken=0; pred_taken=1 -> redirect_pc=pc+4.
REQ-038 SHALL verify JALR op_1=0x3001, imm=0x10, pred_target=0x3010 -> target 0x3010, mispred=0; pc=0xFFFF_FFFF_FFFF_FFFC -> resp_link=0 (wrap).
REQ-039 SHALL verify kill asserted with redirect_ready=1 in REDIR -> IDLE next cycle, mis_cnt unchanged, in_ready=1.
REQ-040 SHALL verify mis_cnt preloaded to 0xFFFF_FFFF stays saturated on further mispredict; clr_cnt with same-cycle increment -> 0.
